// File: rtl/decode_top.sv
// ID stage of the etcpu pipeline: IF/ID register, 32x32 register file with
// writeback bypass, RV32I field/immediate decode, load-use interlock, ID/EX register.
module decode_top #(
  parameter int          DAT_W    = 32,
  parameter int          RF_DEPTH = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      if_pc,
  input  logic             id_branch_taken,
  input  logic [31:0]      id_branch_nt_pc,
  input  logic             ex_branch_flush,
  input  logic             wb_rd_en,
  input  logic [4:0]       wb_rd_addr,
  input  logic [DAT_W-1:0] wb_rd_dat,
  output logic             intrlock_bubble,
  output logic             ex_valid,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [4:0]       ex_rd_addr,
  output logic [4:0]       ex_rs1_addr,
  output logic [4:0]       ex_rs2_addr,
  output logic [DAT_W-1:0] ex_rs1_dat,
  output logic [DAT_W-1:0] ex_rs2_dat,
  output logic [DAT_W-1:0] ex_imm,
  output logic [31:0]      ex_pc,
  output logic             ex_branch_taken,
  output logic [31:0]      ex_branch_nt_pc,
  output logic             ex_mem_rd
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  function automatic logic signed [DAT_W-1:0] imm_decode(input logic [31:0] i);
    logic signed [DAT_W-1:0] imm;
    imm = '0;
    case (i[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm = DAT_W'(signed'(i[31:20]));
      OP_STORE:  imm = DAT_W'(signed'({i[31:25], i[11:7]}));
      OP_BRANCH: imm = DAT_W'(signed'({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      OP_LUI, OP_AUIPC: imm = DAT_W'(signed'({i[31:12], 12'b0}));
      OP_JAL:    imm = DAT_W'(signed'({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default:   imm = '0;
    endcase
    return imm;
  endfunction

  // ---- stage p0: IF/ID register ----
  logic [31:0] inst_p0;
  logic [31:0] pc_p0;
  logic        bt_p0;
  logic [31:0] ntpc_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_p0 <= NOP_INST;
      pc_p0   <= '0;
      bt_p0   <= 1'b0;
      ntpc_p0 <= '0;
    end else if (ex_branch_flush) begin
      inst_p0 <= NOP_INST;
      bt_p0   <= 1'b0;
    end else if (!intrlock_bubble) begin
      inst_p0 <= id_inst;
      pc_p0   <= if_pc;
      bt_p0   <= id_branch_taken;
      ntpc_p0 <= id_branch_nt_pc;
    end
  end

  logic [DAT_W-1:0] rf [RF_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (wb_rd_en && (wb_rd_addr != 5'd0)) begin
      rf[wb_rd_addr] <= wb_rd_dat;
    end
  end

  logic [6:0]              opc_d;
  logic                    rs1_use_d, rs2_use_d;
  logic [4:0]              rs1_idx_d, rs2_idx_d, rd_d;
  logic [DAT_W-1:0]        rs1_dat_d, rs2_dat_d;
  logic signed [DAT_W-1:0] imm_d;

  always_comb begin
    opc_d     = inst_p0[6:0];
    rs1_use_d = !((opc_d == OP_LUI) || (opc_d == OP_AUIPC) || (opc_d == OP_JAL));
    rs2_use_d = (opc_d == OP_OP) || (opc_d == OP_STORE) || (opc_d == OP_BRANCH);
    rs1_idx_d = rs1_use_d ? inst_p0[19:15] : 5'd0;
    rs2_idx_d = rs2_use_d ? inst_p0[24:20] : 5'd0;
    rd_d      = ((opc_d == OP_STORE) || (opc_d == OP_BRANCH)) ? 5'd0 : inst_p0[11:7];
    imm_d     = imm_decode(inst_p0);
    // Writeback in the same cycle wins over the stored entry.
    rs1_dat_d = '0;
    if (rs1_idx_d != 5'd0)
      rs1_dat_d = (wb_rd_en && (wb_rd_addr == rs1_idx_d)) ? wb_rd_dat : rf[rs1_idx_d];
    rs2_dat_d = '0;
    if (rs2_idx_d != 5'd0)
      rs2_dat_d = (wb_rd_en && (wb_rd_addr == rs2_idx_d)) ? wb_rd_dat : rf[rs2_idx_d];
  end

  // ---- stage p1: ID/EX register ----
  logic                    vld_p1;
  logic [6:0]              opc_p1;
  logic [2:0]              f3_p1;
  logic                    f7b5_p1;
  logic [4:0]              rd_p1, rs1_idx_p1, rs2_idx_p1;
  logic [DAT_W-1:0]        rs1_dat_p1, rs2_dat_p1;
  logic signed [DAT_W-1:0] imm_p1;
  logic [31:0]             pc_p1, ntpc_p1;
  logic                    bt_p1, mem_rd_p1;

  // The hazard compares against the pre-mask indices; rs fields of a NOP are x0 and never match.
  always_comb begin
    intrlock_bubble = vld_p1 && mem_rd_p1 && (rd_p1 != 5'd0) && !ex_branch_flush &&
                      ((rs1_use_d && (inst_p0[19:15] == rd_p1)) ||
                       (rs2_use_d && (inst_p0[24:20] == rd_p1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      opc_p1     <= '0;
      f3_p1      <= '0;
      f7b5_p1    <= 1'b0;
      rd_p1      <= '0;
      rs1_idx_p1 <= '0;
      rs2_idx_p1 <= '0;
      rs1_dat_p1 <= '0;
      rs2_dat_p1 <= '0;
      imm_p1     <= '0;
      pc_p1      <= '0;
      bt_p1      <= 1'b0;
      ntpc_p1    <= '0;
      mem_rd_p1  <= 1'b0;
    end else if (ex_branch_flush || intrlock_bubble) begin
      vld_p1    <= 1'b0;
      mem_rd_p1 <= 1'b0;
      rd_p1     <= '0;
    end else begin
      vld_p1     <= (inst_p0 != NOP_INST);
      opc_p1     <= opc_d;
      f3_p1      <= inst_p0[14:12];
      f7b5_p1    <= inst_p0[30];
      rd_p1      <= rd_d;
      rs1_idx_p1 <= rs1_idx_d;
      rs2_idx_p1 <= rs2_idx_d;
      rs1_dat_p1 <= rs1_dat_d;
      rs2_dat_p1 <= rs2_dat_d;
      imm_p1     <= imm_d;
      pc_p1      <= pc_p0;
      bt_p1      <= bt_p0;
      ntpc_p1    <= ntpc_p0;
      mem_rd_p1  <= (opc_d == OP_LOAD);
    end
  end

  assign ex_valid        = vld_p1;
  assign ex_opcode       = opc_p1;
  assign ex_funct3       = f3_p1;
  assign ex_funct7b5     = f7b5_p1;
  assign ex_rd_addr      = rd_p1;
  assign ex_rs1_addr     = rs1_idx_p1;
  assign ex_rs2_addr     = rs2_idx_p1;
  assign ex_rs1_dat      = rs1_dat_p1;
  assign ex_rs2_dat      = rs2_dat_p1;
  assign ex_imm          = imm_p1;
  assign ex_pc           = pc_p1;
  assign ex_branch_taken = bt_p1;
  assign ex_branch_nt_pc = ntpc_p1;
  assign ex_mem_rd       = mem_rd_p1;

endmodule

// File: tb/tb_decode_top.sv
// Directed self-checking bench for decode_top: reset, latency, bypass, x0,
// load-use interlock, flush priority and immediate decode.
module tb_decode_top;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_inst, if_pc, id_branch_nt_pc, wb_rd_dat;
  logic        id_branch_taken, ex_branch_flush, wb_rd_en;
  logic [4:0]  wb_rd_addr;
  logic        intrlock_bubble, ex_valid, ex_funct7b5, ex_branch_taken, ex_mem_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
  logic [31:0] ex_rs1_dat, ex_rs2_dat, ex_imm, ex_pc, ex_branch_nt_pc;

  int checks = 0;
  int errors = 0;

  decode_top dut (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .if_pc(if_pc),
    .id_branch_taken(id_branch_taken), .id_branch_nt_pc(id_branch_nt_pc),
    .ex_branch_flush(ex_branch_flush), .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr),
    .wb_rd_dat(wb_rd_dat), .intrlock_bubble(intrlock_bubble), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_rd_addr(ex_rd_addr), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rs1_dat(ex_rs1_dat), .ex_rs2_dat(ex_rs2_dat), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_branch_taken(ex_branch_taken), .ex_branch_nt_pc(ex_branch_nt_pc),
    .ex_mem_rd(ex_mem_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_inst = NOP; if_pc = '0; id_branch_taken = 1'b0;
    id_branch_nt_pc = '0; ex_branch_flush = 1'b0; wb_rd_en = 1'b0;
    wb_rd_addr = '0; wb_rd_dat = '0;
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", ex_valid); end
    checks++; if ({ex_imm, ex_pc, ex_rd_addr, ex_opcode} !== '0) begin errors++; $display("FAIL reset_fields got %h %h %h %h want 0", ex_imm, ex_pc, ex_rd_addr, ex_opcode); end
    checks++; if (intrlock_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %h want 0", intrlock_bubble); end
    rst_n = 1'b1;
    tick();
    checks++; if ({ex_valid, ex_mem_rd, ex_rs1_dat, ex_rs2_dat} !== '0) begin errors++; $display("FAIL post_reset got %h %h %h %h want 0", ex_valid, ex_mem_rd, ex_rs1_dat, ex_rs2_dat); end
  endtask

  task automatic test_latency();
    id_inst = 32'h00500093; if_pc = 32'h100; id_branch_taken = 1'b1; id_branch_nt_pc = 32'h200;
    tick();
    id_inst = NOP; id_branch_taken = 1'b0;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1_valid got %h want 0", ex_valid); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lat_edge2_valid got %h want 1", ex_valid); end
    checks++; if (ex_pc !== 32'h100 || ex_branch_taken !== 1'b1 || ex_branch_nt_pc !== 32'h200) begin errors++; $display("FAIL lat_pc_pred got %h %h %h want 100 1 200", ex_pc, ex_branch_taken, ex_branch_nt_pc); end
    checks++; if (ex_imm !== 32'd5 || ex_rd_addr !== 5'd1 || ex_opcode !== 7'h13 || ex_mem_rd !== 1'b0) begin errors++; $display("FAIL lat_decode got %h %h %h %h want 5 1 13 0", ex_imm, ex_rd_addr, ex_opcode, ex_mem_rd); end
  endtask

  task automatic test_bypass();
    id_inst = 32'h000280B3;
    tick();
    id_inst = NOP;
    wb_rd_en = 1'b1; wb_rd_addr = 5'd5; wb_rd_dat = 32'hDEADBEEF;
    tick();
    wb_rd_en = 1'b0;
    checks++; if (ex_rs1_dat !== 32'hDEADBEEF || ex_rs1_addr !== 5'd5) begin errors++; $display("FAIL bypass_rs1 got %h idx %0d want deadbeef idx 5", ex_rs1_dat, ex_rs1_addr); end
    checks++; if (ex_rs2_dat !== 32'h0 || ex_rd_addr !== 5'd1 || ex_opcode !== 7'h33) begin errors++; $display("FAIL bypass_other got %h %h %h want 0 1 33", ex_rs2_dat, ex_rd_addr, ex_opcode); end
    wb_rd_en = 1'b1; wb_rd_addr = 5'd1; wb_rd_dat = 32'h11111111;
    id_inst = 32'h000280B3;
    tick();
    wb_rd_en = 1'b1; wb_rd_addr = 5'd0; wb_rd_dat = 32'h12345678;
    id_inst = 32'h00100233;
    tick();
    wb_rd_en = 1'b0; id_inst = NOP;
    checks++; if (ex_rs1_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_read_x5 got %h want deadbeef", ex_rs1_dat); end
    tick();
    checks++; if (ex_rs1_dat !== 32'h0 || ex_rs2_dat !== 32'h11111111) begin errors++; $display("FAIL x0_write got rs1 %h rs2 %h want 0 11111111", ex_rs1_dat, ex_rs2_dat); end
  endtask

  task automatic test_load_use();
    id_inst = 32'h00012183;
    tick();
    id_inst = 32'h00118233;
    checks++; if (intrlock_bubble !== 1'b0) begin errors++; $display("FAIL lu_pre_bubble got %h want 0", intrlock_bubble); end
    tick();
    id_inst = NOP;
    checks++; if (intrlock_bubble !== 1'b1 || ex_mem_rd !== 1'b1 || ex_rd_addr !== 5'd3) begin errors++; $display("FAIL lu_stall got %h %h %h want 1 1 3", intrlock_bubble, ex_mem_rd, ex_rd_addr); end
    tick();
    checks++; if (ex_valid !== 1'b0 || intrlock_bubble !== 1'b0 || ex_rd_addr !== 5'd0) begin errors++; $display("FAIL lu_bubble got %h %h %h want 0 0 0", ex_valid, intrlock_bubble, ex_rd_addr); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rs1_addr !== 5'd3 || ex_rs2_addr !== 5'd1 || ex_rd_addr !== 5'd4) begin errors++; $display("FAIL lu_add got %h %h %h %h want 1 3 1 4", ex_valid, ex_rs1_addr, ex_rs2_addr, ex_rd_addr); end
    checks++; if (ex_rs2_dat !== 32'h11111111) begin errors++; $display("FAIL lu_add_rs2 got %h want 11111111", ex_rs2_dat); end
  endtask

  task automatic test_no_stall();
    id_inst = 32'h00012003;
    tick();
    id_inst = 32'h00100233;
    tick();
    id_inst = NOP;
    checks++; if (intrlock_bubble !== 1'b0) begin errors++; $display("FAIL lw_x0_bubble got %h want 0", intrlock_bubble); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd_addr !== 5'd4) begin errors++; $display("FAIL lw_x0_add got %h %h want 1 4", ex_valid, ex_rd_addr); end
    id_inst = 32'h00012183;
    tick();
    id_inst = 32'h000011B7;
    tick();
    id_inst = NOP;
    checks++; if (intrlock_bubble !== 1'b0) begin errors++; $display("FAIL lui_bubble got %h want 0", intrlock_bubble); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_opcode !== 7'h37 || ex_imm !== 32'h00001000 || ex_rs1_addr !== 5'd0) begin errors++; $display("FAIL lui_decode got %h %h %h %h want 1 37 1000 0", ex_valid, ex_opcode, ex_imm, ex_rs1_addr); end
  endtask

  task automatic test_flush();
    id_inst = 32'h00012183;
    tick();
    id_inst = 32'h00718313;
    tick();
    id_inst = NOP;
    checks++; if (intrlock_bubble !== 1'b1) begin errors++; $display("FAIL flush_pre_stall got %h want 1", intrlock_bubble); end
    ex_branch_flush = 1'b1;
    #1;
    checks++; if (intrlock_bubble !== 1'b0) begin errors++; $display("FAIL flush_bubble_mask got %h want 0", intrlock_bubble); end
    tick();
    ex_branch_flush = 1'b0;
    checks++; if (ex_valid !== 1'b0 || ex_mem_rd !== 1'b0 || intrlock_bubble !== 1'b0) begin errors++; $display("FAIL flush_idex got %h %h %h want 0 0 0", ex_valid, ex_mem_rd, intrlock_bubble); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_opcode !== 7'h13 || ex_rd_addr !== 5'd0) begin errors++; $display("FAIL flush_ifid_nop got %h %h %h want 0 13 0", ex_valid, ex_opcode, ex_rd_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [5] = '{32'hFE000EE3, 32'hFE000E63, 32'h800000EF, 32'hFE112E23, 32'h00718313};
    logic [31:0] imms  [5] = '{32'hFFFFFFFC, 32'hFFFFF7FC, 32'hFFF00000, 32'hFFFFFFFC, 32'h00000007};
    logic [4:0]  rds   [5] = '{5'd0, 5'd0, 5'd1, 5'd0, 5'd6};
    logic [4:0]  rs1s  [5] = '{5'd0, 5'd0, 5'd0, 5'd2, 5'd3};
    logic [4:0]  rs2s  [5] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd0};
    for (int i = 0; i <= 5; i++) begin
      id_inst = (i < 5) ? insts[i] : NOP;
      tick();
      if (i >= 1) begin
        checks++;
        if (ex_valid !== 1'b1 || ex_imm !== imms[i-1] || ex_rd_addr !== rds[i-1] ||
            ex_rs1_addr !== rs1s[i-1] || ex_rs2_addr !== rs2s[i-1])
        begin
          errors++;
          $display("FAIL imm_%0d got v%h imm %h rd %0d rs1 %0d rs2 %0d want v1 imm %h rd %0d rs1 %0d rs2 %0d",
                   i-1, ex_valid, ex_imm, ex_rd_addr, ex_rs1_addr, ex_rs2_addr,
                   imms[i-1], rds[i-1], rs1s[i-1], rs2s[i-1]);
        end
      end
    end
    checks++; if (ex_rs2_dat !== 32'h0 || ex_rs1_dat !== 32'h0) begin errors++; $display("FAIL addi_x3_dat got %h %h want 0 0", ex_rs1_dat, ex_rs2_dat); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bypass();
    test_load_use();
    test_no_stall();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
